// File: rtl/rom_scan_ctrl_if.sv
// ROM read port plus the one-entry output stream of the scan controller.
// Handshake: the producer raises out_valid with out_data held stable, and a byte transfers on
// any rising edge where out_valid && out_ready. The producer never drops out_valid without a transfer.
interface rom_scan_ctrl_if;
  logic [3:0] rom_addr;
  logic       rom_rd_en;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output rom_addr, rom_rd_en, out_data, out_valid,
    input  rom_data, out_ready
  );

  modport slave (
    input  rom_addr, rom_rd_en, out_data, out_valid,
    output rom_data, out_ready
  );
endinterface

// File: rtl/rom_scan_ctrl.sv
// Scans a wrap-around range of the 16x8 ROM and streams each byte through a one-entry
// valid/ready register, while accumulating the sum and maximum of the bytes read.
module rom_scan_ctrl (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             start_addr,
  input  logic [4:0]             count,
  rom_scan_ctrl_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic [11:0]            sum,
  output logic [7:0]             max_val,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q,     state_d;
  logic [3:0]  cur_addr_q,  cur_addr_d;
  logic [4:0]  remaining_q, remaining_d;
  logic [7:0]  out_data_q,  out_data_d;
  logic        out_valid_q, out_valid_d;
  logic [11:0] sum_q,       sum_d;
  logic [7:0]  max_q,       max_d;
  logic        rd_en;
  logic        xfer;

  assign xfer = out_valid_q & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    max_d       = max_q;
    rd_en       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    // A transfer empties the slot; a capture on the same edge refills it below.
    if (xfer) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr_d  = start_addr;
          remaining_d = count;
          sum_d       = '0;
          max_d       = '0;
          state_d     = (count != 5'd0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        busy  = 1'b1;
        rd_en = !out_valid_q || bus.out_ready;
        if (rd_en) begin
          out_data_d  = bus.rom_data;
          out_valid_d = 1'b1;
          sum_d       = sum_q + {4'h0, bus.rom_data};
          max_d       = (bus.rom_data > max_q) ? bus.rom_data : max_q;
          cur_addr_d  = cur_addr_q + 4'd1;
          remaining_d = remaining_q - 5'd1;
          if (remaining_q == 5'd1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (xfer) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      max_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
    end
  end

  assign bus.rom_addr  = cur_addr_q;
  assign bus.rom_rd_en = rd_en;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign sum           = sum_q;
  assign max_val       = max_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Directed bench for rom_scan_ctrl; the bench ROM holds ROM[i] = 0x11*i.
module tb_rom_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  start_addr;
  logic [4:0]  count;
  logic        busy;
  logic        done;
  logic [11:0] sum;
  logic [7:0]  max_val;
  logic [1:0]  state_dbg;

  rom_scan_ctrl_if bus ();

  rom_scan_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .max_val    (max_val),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / ROM model ----------------
  always #5 clk = ~clk;
  assign bus.rom_data = {4'h0, bus.rom_addr} * 8'h11;

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [3:0] exp_addr_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("sb_extra_byte", 32'(bus.out_data), 32'h100);
        else                   check("sb_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
      if (bus.rom_rd_en) begin
        if (exp_addr_q.size() == 0) check("sb_extra_read", 32'(bus.rom_addr), 32'h10);
        else                        check("sb_addr", 32'(bus.rom_addr), 32'(exp_addr_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_scan(input logic [3:0] a, input logic [4:0] c);
    start      = 1'b1;
    start_addr = a;
    count      = c;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_addr"},  32'(bus.rom_addr),  32'h0);
    check({tag, "_rd_en"},     32'(bus.rom_rd_en), 32'h0);
    check({tag, "_out_data"},  32'(bus.out_data),  32'h0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
    check({tag, "_busy"},      32'(busy),          32'h0);
    check({tag, "_done"},      32'(done),          32'h0);
    check({tag, "_sum"},       32'(sum),           32'h0);
    check({tag, "_max"},       32'(max_val),       32'h0);
    check({tag, "_state"},     32'(state_dbg),     32'h0);
  endtask

  task automatic settle_and_clear();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    start_addr    = 4'h0;
    count         = 5'd0;
    bus.out_ready = 1'b1;
    #12;
    check_reset_vals("por");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic scan: 2,3,4 -> 0x22,0x33,0x44
    busy_cnt = 0; done_cnt = 0;
    exp_q      = '{8'h22, 8'h33, 8'h44};
    exp_addr_q = '{4'd2, 4'd3, 4'd4};
    start_scan(4'd2, 5'd3);
    wait_done("basic");
    settle_and_clear();
    check("basic_sum",      32'(sum),       32'h099);
    check("basic_max",      32'(max_val),   32'h44);
    check("basic_busy_len", 32'(busy_cnt),  32'd4);
    check("basic_done_cnt", 32'(done_cnt),  32'd1);
    check("basic_sb_empty", 32'(exp_q.size()), 32'd0);

    // Wrap-around: 14,15,0,1
    busy_cnt = 0; done_cnt = 0;
    exp_q      = '{8'hEE, 8'hFF, 8'h00, 8'h11};
    exp_addr_q = '{4'd14, 4'd15, 4'd0, 4'd1};
    start_scan(4'd14, 5'd4);
    wait_done("wrap");
    settle_and_clear();
    check("wrap_sum",      32'(sum),      32'h1FE);
    check("wrap_max",      32'(max_val),  32'hFF);
    check("wrap_busy_len", 32'(busy_cnt), 32'd5);
    check("wrap_sb_empty", 32'(exp_q.size() + exp_addr_q.size()), 32'd0);

    // Full scan with a 3-cycle stall after the first byte
    done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i * 17));
      exp_addr_q.push_back(4'(i));
    end
    start_scan(4'd0, 5'd16);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_data",  32'(bus.out_data),  32'h00);
      check("bp_rd_en",     32'(bus.rom_rd_en), 32'd0);
      check("bp_rom_addr",  32'(bus.rom_addr),  32'd1);
      check("bp_sum",       32'(sum),           32'h000);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done("full");
    settle_and_clear();
    check("full_sum",      32'(sum),      32'h7F8);
    check("full_max",      32'(max_val),  32'hFF);
    check("full_done_cnt", 32'(done_cnt), 32'd1);
    check("full_sb_empty", 32'(exp_q.size() + exp_addr_q.size()), 32'd0);

    // Zero count: done in the cycle after start, sum cleared, no output
    done_cnt = 0; busy_cnt = 0;
    start_scan(4'd7, 5'd0);
    @(negedge clk);
    check("zero_done",      32'(done),          32'd1);
    check("zero_out_valid", 32'(bus.out_valid), 32'd0);
    check("zero_sum",       32'(sum),           32'h000);
    check("zero_max",       32'(max_val),       32'h00);
    @(posedge clk); #1;
    @(negedge clk);
    check("zero_done_clr",  32'(done),          32'd0);
    settle_and_clear();
    check("zero_done_cnt",  32'(done_cnt),      32'd1);
    check("zero_busy_cnt",  32'(busy_cnt),      32'd0);

    // Second start while busy must be ignored and not queued
    done_cnt = 0; busy_cnt = 0;
    exp_q      = '{8'h22, 8'h33, 8'h44};
    exp_addr_q = '{4'd2, 4'd3, 4'd4};
    start_scan(4'd2, 5'd3);
    start_scan(4'd9, 5'd5);
    wait_done("ign");
    repeat (5) @(posedge clk);
    #1;
    check("ign_sum",      32'(sum),      32'h099);
    check("ign_busy_len", 32'(busy_cnt), 32'd4);
    check("ign_done_cnt", 32'(done_cnt), 32'd1);
    check("ign_state",    32'(state_dbg), 32'd0);

    // Reset mid-scan while the second byte is being read
    done_cnt = 0;
    exp_q      = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    exp_addr_q = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    start_scan(4'd4, 5'd5);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_vals("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt), 32'd0);

    // Clean scan after the reset
    done_cnt = 0; busy_cnt = 0;
    exp_q      = '{8'h22, 8'h33, 8'h44};
    exp_addr_q = '{4'd2, 4'd3, 4'd4};
    start_scan(4'd2, 5'd3);
    wait_done("post");
    settle_and_clear();
    check("post_sum",      32'(sum),      32'h099);
    check("post_max",      32'(max_val),  32'h44);
    check("post_busy_len", 32'(busy_cnt), 32'd4);
    check("post_sb_empty", 32'(exp_q.size() + exp_addr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
